// File: rtl/ffd_posedge_async_reset.sv
// Generic SIZE-bit positive-edge storage register with load enable and asynchronous low-true clear.
// Q comes straight from the flops, so downstream logic never sees gated or combinational glitches.
module ffd_posedge_async_reset #(
  parameter int SIZE = 1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  input  logic [SIZE-1:0] D,
  output logic [SIZE-1:0] Q
);

  // Clear has priority over a coincident load; deassertion is expected to be synchronized upstream.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Q <= '0;
    end else if (Enable) begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_ffd_posedge_async_reset.sv
// Bench for ffd_posedge_async_reset at SIZE = 32, 16 and 1, using directed and random stimulus.
// Each instance is compared against a "last value loaded since clear" model.
module tb_ffd_posedge_async_reset;

  logic        Clock;
  logic        Reset;
  logic        en32, en16, en1;
  logic [31:0] d32, q32;
  logic [15:0] d16, q16;
  logic        d1, q1;

  logic [31:0] m32;
  logic [15:0] m16;
  logic        m1;

  int checks = 0;
  int errors = 0;

  ffd_posedge_async_reset #(.SIZE(32)) dut32 (
    .Clock(Clock), .Reset(Reset), .Enable(en32), .D(d32), .Q(q32)
  );
  ffd_posedge_async_reset #(.SIZE(16)) dut16 (
    .Clock(Clock), .Reset(Reset), .Enable(en16), .D(d16), .Q(q16)
  );
  ffd_posedge_async_reset #(.SIZE(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Enable(en1), .D(d1), .Q(q1)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q32"}, q32, m32);
    chk({tag, "_q16"}, {16'h0, q16}, {16'h0, m16});
    chk({tag, "_q1"}, {31'h0, q1}, {31'h0, m1});
  endtask

  task automatic clear_model();
    m32 = '0;
    m16 = '0;
    m1  = 1'b0;
  endtask

  // One rising edge: update the model from the sampled inputs, check, then park at the next falling edge.
  task automatic tick(input string tag);
    @(posedge Clock);
    if (!Reset) begin
      clear_model();
    end else begin
      if (en32) m32 = d32;
      if (en16) m16 = d16;
      if (en1)  m1  = d1;
    end
    #1;
    check_all(tag);
    @(negedge Clock);
  endtask

  task automatic set_all(input logic en, input logic [31:0] d);
    en32 = en; en16 = en; en1 = en;
    d32 = d; d16 = d[15:0]; d1 = d[0];
  endtask

  initial begin
    Reset = 1'b0;
    set_all(1'b1, 32'hDEADBEEF);
    clear_model();
    #1;
    check_all("reset_initial");
    @(negedge Clock);

    // Held in clear with load requested
    for (int i = 0; i < 3; i++) tick("reset_hold");
    Reset = 1'b1;
    #1;
    check_all("release_no_edge");
    tick("first_load");

    // Enable gating
    set_all(1'b1, 32'h12345678);
    tick("gate_load");
    set_all(1'b0, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) tick("gate_hold");
    set_all(1'b1, 32'hFFFFFFFF);
    tick("gate_reload");

    // Mid-cycle asynchronous clear
    set_all(1'b1, 32'hA5A5A5A5);
    tick("pre_clear_load");
    #2;
    Reset = 1'b0;
    clear_model();
    #1;
    check_all("async_clear");
    @(negedge Clock);
    for (int i = 0; i < 3; i++) begin
      set_all(1'b1, (i % 2) ? 32'h5A5A5A5A : 32'hA5A5A5A5);
      tick("clear_hold");
    end
    Reset = 1'b1;

    // Streaming loads
    for (int i = 1; i <= 4; i++) begin
      set_all(1'b1, i);
      tick("stream");
    end

    // Width checks
    set_all(1'b1, 32'h00008001);
    d32 = 32'h80000001;
    tick("width_8001");
    for (int i = 0; i < 4; i++) begin
      set_all(1'b1, 32'hFFFF0000 | i);
      tick("width_toggle");
    end

    // Clear coincident with a rising edge while loading
    set_all(1'b1, 32'h1);
    @(posedge Clock);
    Reset = 1'b0;
    clear_model();
    #1;
    check_all("race_clear");
    @(negedge Clock);
    Reset = 1'b1;
    tick("race_recover");

    // Random traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      en32 = 1'($urandom_range(0, 1));
      en16 = 1'($urandom_range(0, 1));
      en1  = 1'($urandom_range(0, 1));
      d32  = $urandom;
      d16  = 16'($urandom);
      d1   = 1'($urandom);
      Reset = ($urandom_range(0, 15) != 0);
      if (!Reset) begin
        #1;
        clear_model();
        check_all("rnd_async");
      end
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
